// File: rtl/loop_sequencer_if.sv
// Handshake bundle between the control-loop glue and the sample-rate scheduler.
// master: drives run/period/adc_done/err_clr; slave (sequencer): drives pulses, status and flags.
interface loop_sequencer_if #(
   parameter int PERIOD_W = 16
);
   logic                run;
   logic [PERIOD_W-1:0] period;
   logic                adc_done;
   logic                err_clr;
   logic                adc_start;
   logic                pid_en;
   logic                pwm_load;
   logic                busy;
   logic                timeout_err;
   logic                overrun_err;
   logic [7:0]          sample_cnt;

   modport master (
      output run, period, adc_done, err_clr,
      input  adc_start, pid_en, pwm_load, busy,
      input  timeout_err, overrun_err, sample_cnt
   );

   modport slave (
      input  run, period, adc_done, err_clr,
      output adc_start, pid_en, pwm_load, busy,
      output timeout_err, overrun_err, sample_cnt
   );
endinterface

// File: rtl/loop_sequencer.sv
// Sample-rate scheduler: periodic tick -> ADC start -> PID step -> PWM load, with fault flags.
// Ports: clk, rst (async, active-low), bus (loop_sequencer_if.slave: run/period/adc_done/err_clr in; pulses/flags/count out).
module loop_sequencer #(
   parameter int PERIOD_W = 16,
   parameter int TIMEOUT  = 64,
   parameter int PID_LAT  = 3
) (
   input  logic           clk,
   input  logic           rst,
   loop_sequencer_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int LW = $clog2(PID_LAT + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ADC,
      PID_WAIT
   } state_t;

   state_t              state, state_n;
   logic [PERIOD_W-1:0] pcnt, reload;
   logic                tick;
   logic [TW-1:0]       tcnt, tcnt_n;
   logic [LW-1:0]       lcnt, lcnt_n;
   logic                start_q, start_n;
   logic                pid_q, pid_n;
   logic                pwm_q, pwm_n;
   logic                to_q, to_set;
   logic                ov_q, ov_set;
   logic                inc;
   logic [7:0]          scnt;

   // Periods below 2 would leave no room between ticks; clamp to 2.
   assign reload = (bus.period < PERIOD_W'(2)) ? PERIOD_W'(1)
                                               : bus.period - PERIOD_W'(1);
   assign tick   = bus.run && (pcnt == '0);
   assign ov_set = tick && (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcnt <= '0;
      end else if (!bus.run) begin
         pcnt <= '0;
      end else if (tick) begin
         pcnt <= reload;
      end else begin
         pcnt <= pcnt - PERIOD_W'(1);
      end
   end

   always_comb begin
      state_n = state;
      tcnt_n  = tcnt;
      lcnt_n  = lcnt;
      start_n = 1'b0;
      pid_n   = 1'b0;
      pwm_n   = 1'b0;
      to_set  = 1'b0;
      inc     = 1'b0;
      unique case (state)
         IDLE: begin
            if (tick) begin
               state_n = WAIT_ADC;
               start_n = 1'b1;
               tcnt_n  = '0;
            end
         end
         WAIT_ADC: begin
            if (bus.adc_done) begin
               state_n = PID_WAIT;
               pid_n   = 1'b1;
               lcnt_n  = '0;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               state_n = IDLE;
               to_set  = 1'b1;
            end else begin
               tcnt_n = tcnt + TW'(1);
            end
         end
         PID_WAIT: begin
            // lcnt is 0 in the pid_en cycle, so the load lands PID_LAT later.
            if (lcnt == LW'(PID_LAT - 1)) begin
               state_n = IDLE;
               pwm_n   = 1'b1;
               inc     = 1'b1;
            end else begin
               lcnt_n = lcnt + LW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         tcnt    <= '0;
         lcnt    <= '0;
         start_q <= 1'b0;
         pid_q   <= 1'b0;
         pwm_q   <= 1'b0;
         to_q    <= 1'b0;
         ov_q    <= 1'b0;
         scnt    <= '0;
      end else begin
         state   <= state_n;
         tcnt    <= tcnt_n;
         lcnt    <= lcnt_n;
         start_q <= start_n;
         pid_q   <= pid_n;
         pwm_q   <= pwm_n;
         // A set event in the clearing cycle keeps the flag.
         to_q    <= to_set | (to_q & ~bus.err_clr);
         ov_q    <= ov_set | (ov_q & ~bus.err_clr);
         if (inc) begin
            scnt <= scnt + 8'd1;
         end
      end
   end

   assign bus.adc_start   = start_q;
   assign bus.pid_en      = pid_q;
   assign bus.pwm_load    = pwm_q;
   assign bus.busy        = (state != IDLE);
   assign bus.timeout_err = to_q;
   assign bus.overrun_err = ov_q;
   assign bus.sample_cnt  = scnt;
endmodule
